// File: rtl/inst_cache_pkg.sv
// Shared pipeline types: instruction-cache geometry defaults and controller state encoding.
package pipeline_types;

    localparam int ICACHE_SETS       = 256;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int WORD_W            = 32;

    typedef enum logic [1:0] {
        IC_IDLE,
        IC_MISS,
        IC_REFILL
    } icache_state_t;

endpackage

// File: rtl/inst_cache_if.sv
// Line-refill bus between the instruction cache (master) and the memory side (slave).
interface inst_cache_if;
    import pipeline_types::*;

    logic              rd_req;
    logic [WORD_W-1:0] rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [WORD_W-1:0] ret_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_rdy,
        input  ret_valid,
        input  ret_last,
        input  ret_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_rdy,
        output ret_valid,
        output ret_last,
        output ret_data
    );

endinterface

// File: rtl/inst_cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous read, one full-line write port.
module icache_line_array
    import pipeline_types::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int TAG_W      = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(SETS)-1:0]      rd_idx,
    output logic                         rd_valid,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [LINE_WORDS*WORD_W-1:0] rd_line,
    input  logic                         wr_en,
    input  logic [$clog2(SETS)-1:0]      wr_idx,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_WORDS*WORD_W-1:0] wr_line
);

    logic [SETS-1:0]  valid_reg;
    logic [TAG_W-1:0] tag_mem [SETS];

    // Valid bits are the only state that must be cleared; stale tags/data are masked by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];

    // One word-wide array per line slot keeps each RAM narrow.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] word_mem [SETS];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    word_mem[wr_idx] <= wr_line[gi*WORD_W +: WORD_W];
                end
            end

            assign rd_line[gi*WORD_W +: WORD_W] = word_mem[rd_idx];
        end
    endgenerate

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: one-cycle hits from a registered fetch PC,
// stall-and-refill on a miss, and branch_flush that drops responses without corrupting the array.
module inst_cache
    import pipeline_types::*;
#(
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc,
    input  logic              inst_en,
    input  logic              branch_flush,
    output logic              stall,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] pc_out,
    output logic              is_valid_out,
    inst_cache_if.master      mem
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = WORD_W - TAG_LSB;
    localparam int LINE_W  = LINE_WORDS * WORD_W;

    icache_state_t     state_reg;
    logic [WORD_W-1:0] req_pc_reg;
    logic              req_vld_reg;
    logic [OFF_W-1:0]  beat_reg;
    logic              flush_pend_reg;
    logic              rd_req_reg;
    logic [WORD_W-1:0] rd_addr_reg;
    logic [WORD_W-1:0] line_buf_reg [LINE_WORDS];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  req_off;
    logic              arr_valid;
    logic [TAG_W-1:0]  arr_tag;
    logic [LINE_W-1:0] arr_line;
    logic [LINE_W-1:0] fill_line;
    logic [WORD_W-1:0] line_words [LINE_WORDS];
    logic              hit;
    logic              lookup_miss;
    logic              accept;
    logic              fill_done;

    assign req_idx = req_pc_reg[TAG_LSB-1:IDX_LSB];
    assign req_tag = req_pc_reg[WORD_W-1:TAG_LSB];
    assign req_off = req_pc_reg[IDX_LSB-1:2];

    icache_line_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_line  (arr_line),
        .wr_en    (fill_done),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_line  (fill_line)
    );

    // The final beat bypasses the buffer so the line installs on the ret_last edge itself.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line
            assign line_words[gi] = arr_line[gi*WORD_W +: WORD_W];
            assign fill_line[gi*WORD_W +: WORD_W] =
                (beat_reg == OFF_W'(gi)) ? mem.ret_data : line_buf_reg[gi];
        end
    endgenerate

    assign hit          = req_vld_reg && arr_valid && (arr_tag == req_tag);
    assign lookup_miss  = (state_reg == IC_IDLE) && req_vld_reg && !hit && !branch_flush;
    assign stall        = (state_reg != IC_IDLE) || lookup_miss;
    assign is_valid_out = (state_reg == IC_IDLE) && hit && !branch_flush;
    assign inst         = is_valid_out ? line_words[req_off] : '0;
    assign pc_out       = is_valid_out ? req_pc_reg : '0;
    assign accept       = inst_en && !stall && !branch_flush;
    assign fill_done    = (state_reg == IC_REFILL) && mem.ret_valid && mem.ret_last;

    assign mem.rd_req  = rd_req_reg;
    assign mem.rd_addr = rd_addr_reg;

    always_ff @(posedge clk) begin
        if (state_reg == IC_REFILL && mem.ret_valid) begin
            line_buf_reg[beat_reg] <= mem.ret_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IC_IDLE;
            req_pc_reg     <= '0;
            req_vld_reg    <= 1'b0;
            beat_reg       <= '0;
            flush_pend_reg <= 1'b0;
            rd_req_reg     <= 1'b0;
            rd_addr_reg    <= '0;
        end else begin
            // The request holds across a stall so the lookup can be replayed after refill.
            if (accept) begin
                req_pc_reg  <= pc;
                req_vld_reg <= 1'b1;
            end else if (!stall) begin
                req_vld_reg <= 1'b0;
            end

            case (state_reg)
                IC_IDLE: begin
                    if (lookup_miss) begin
                        state_reg   <= IC_MISS;
                        rd_req_reg  <= 1'b1;
                        rd_addr_reg <= {req_pc_reg[WORD_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
                    end
                end

                IC_MISS: begin
                    if (mem.rd_rdy) begin
                        // Once memory has accepted, the burst must be drained; a flush only sticks.
                        state_reg      <= IC_REFILL;
                        rd_req_reg     <= 1'b0;
                        beat_reg       <= '0;
                        flush_pend_reg <= branch_flush;
                    end else if (branch_flush) begin
                        state_reg   <= IC_IDLE;
                        rd_req_reg  <= 1'b0;
                        req_vld_reg <= 1'b0;
                    end
                end

                IC_REFILL: begin
                    if (branch_flush) begin
                        flush_pend_reg <= 1'b1;
                    end
                    // ret_last alone ends the burst; the counter simply wraps if it runs long.
                    if (mem.ret_valid) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (mem.ret_last) begin
                            state_reg      <= IC_IDLE;
                            beat_reg       <= '0;
                            flush_pend_reg <= 1'b0;
                            if (flush_pend_reg || branch_flush) begin
                                req_vld_reg <= 1'b0;
                            end
                        end
                    end
                end

                default: state_reg <= IC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: miss/refill timing, sequential hits, conflicts, flushes and reset.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        inst_en;
    logic        branch_flush;
    logic        stall;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        is_valid_out;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_cache_if bus ();

    inst_cache #(
        .SETS       (256),
        .LINE_WORDS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .inst_en      (inst_en),
        .branch_flush (branch_flush),
        .stall        (stall),
        .inst         (inst),
        .pc_out       (pc_out),
        .is_valid_out (is_valid_out),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full miss: lookup, MISS for rdy_delay cycles, accept, four beats; ends in the replay cycle.
    task automatic run_miss(input logic [31:0] addr, input logic [31:0] d0, input int rdy_delay,
                            input int flush_beat, input logic expect_resp);
        logic [31:0] line_addr;
        logic [31:0] want;
        line_addr = {addr[31:4], 4'h0};
        want      = d0 + 32'(addr[3:2]);
        pc = addr; inst_en = 1'b1;
        tick;
        #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL miss_lookup_stall addr=%h: got %b want 1", addr, stall); end
        tests_run++; if (is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL miss_lookup_valid addr=%h: got %b want 0", addr, is_valid_out); end
        tick;
        for (int i = 0; i <= rdy_delay; i++) begin
            if (i == rdy_delay) bus.rd_rdy = 1'b1;
            #1;
            tests_run++; if (bus.rd_req !== 1'b1) begin tests_failed++; $display("FAIL rd_req_held cyc=%0d: got %b want 1", i, bus.rd_req); end
            tests_run++; if (bus.rd_addr !== line_addr) begin tests_failed++; $display("FAIL rd_addr: got %h want %h", bus.rd_addr, line_addr); end
            tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL miss_stall cyc=%0d: got %b want 1", i, stall); end
            tick;
        end
        bus.rd_rdy = 1'b0;
        #1;
        tests_run++; if (bus.rd_req !== 1'b0) begin tests_failed++; $display("FAIL rd_req_drop: got %b want 0", bus.rd_req); end
        for (int b = 0; b < 4; b++) begin
            bus.ret_valid = 1'b1;
            bus.ret_data  = d0 + 32'(b);
            bus.ret_last  = (b == 3);
            branch_flush  = (b == flush_beat);
            #1;
            tests_run++; if (stall !== 1'b1 || is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL refill_beat%0d: stall=%b valid=%b want 1/0", b, stall, is_valid_out); end
            tick;
        end
        bus.ret_valid = 1'b0; bus.ret_last = 1'b0; branch_flush = 1'b0;
        #1;
        if (expect_resp) begin
            tests_run++; if (is_valid_out !== 1'b1) begin tests_failed++; $display("FAIL replay_valid addr=%h: got %b want 1", addr, is_valid_out); end
            tests_run++; if (inst !== want) begin tests_failed++; $display("FAIL replay_inst addr=%h: got %h want %h", addr, inst, want); end
            tests_run++; if (pc_out !== addr) begin tests_failed++; $display("FAIL replay_pc: got %h want %h", pc_out, addr); end
        end else begin
            tests_run++; if (is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL flushed_no_resp addr=%h: got %b want 0", addr, is_valid_out); end
        end
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL replay_stall addr=%h: got %b want 0", addr, stall); end
        $display("[TB] miss addr=%h delay=%0d flush_beat=%0d valid=%b inst=%h", addr, rdy_delay, flush_beat, is_valid_out, inst);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        #1;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests_run++; if (is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", is_valid_out); end
        tests_run++; if (bus.rd_req !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_req: got %b want 0", bus.rd_req); end
        tests_run++; if (bus.rd_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_addr: got %h want 0", bus.rd_addr); end
        tests_run++; if (inst !== 32'h0 || pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_pc: got %h/%h want 0/0", inst, pc_out); end
        rst = 1'b0;
        $display("[TB] reset done");
    endtask

    task automatic test_cold_miss_sequential;
        run_miss(32'h1C00_0000, 32'hA0, 2, -1, 1'b1);
        for (int i = 1; i < 4; i++) begin
            pc = 32'h1C00_0000 + 32'(4 * i);
            tick;
            #1;
            tests_run++; if (is_valid_out !== 1'b1 || stall !== 1'b0) begin tests_failed++; $display("FAIL seq_hit%0d: valid=%b stall=%b want 1/0", i, is_valid_out, stall); end
            tests_run++; if (inst !== 32'hA0 + 32'(i)) begin tests_failed++; $display("FAIL seq_inst%0d: got %h want %h", i, inst, 32'hA0 + 32'(i)); end
            tests_run++; if (pc_out !== pc) begin tests_failed++; $display("FAIL seq_pc%0d: got %h want %h", i, pc_out, pc); end
            $display("[TB] hit pc=%h inst=%h", pc_out, inst);
        end
        inst_en = 1'b0;
        tick;
        #1;
        tests_run++; if (is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL idle_after_seq: got %b want 0", is_valid_out); end
    endtask

    task automatic test_conflict;
        run_miss(32'h1C00_1000, 32'hB0, 0, -1, 1'b1);
        inst_en = 1'b0;
        tick;
        run_miss(32'h1C00_0000, 32'hC0, 0, -1, 1'b1);
        inst_en = 1'b0;
        tick;
    endtask

    task automatic test_flush_on_hit;
        pc = 32'h1C00_0004; inst_en = 1'b1;
        tick;
        #1;
        tests_run++; if (is_valid_out !== 1'b1 || inst !== 32'hC1) begin tests_failed++; $display("FAIL flushhit_pre: valid=%b inst=%h want 1/000000c1", is_valid_out, inst); end
        branch_flush = 1'b1;
        #1;
        tests_run++; if (is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL valid_with_flush: got %b want 0", is_valid_out); end
        tick;
        branch_flush = 1'b0; inst_en = 1'b0;
        #1;
        tests_run++; if (is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL flush_dropped_req: got %b want 0", is_valid_out); end
        $display("[TB] flush on hit pc=%h", pc);
    endtask

    task automatic test_flush_in_refill;
        run_miss(32'h1C00_2018, 32'hD0, 1, 2, 1'b0);
        tick;
        #1;
        tests_run++; if (is_valid_out !== 1'b1 || stall !== 1'b0) begin tests_failed++; $display("FAIL post_flush_hit: valid=%b stall=%b want 1/0", is_valid_out, stall); end
        tests_run++; if (inst !== 32'hD2) begin tests_failed++; $display("FAIL post_flush_inst: got %h want 000000d2", inst); end
        $display("[TB] refetch after flushed refill pc=%h inst=%h", pc_out, inst);
        inst_en = 1'b0;
        tick;
    endtask

    task automatic test_flush_in_miss;
        pc = 32'h1C00_3000; inst_en = 1'b1;
        tick;
        tick;
        #1;
        tests_run++; if (bus.rd_req !== 1'b1) begin tests_failed++; $display("FAIL miss_rd_req: got %b want 1", bus.rd_req); end
        branch_flush = 1'b1; inst_en = 1'b0;
        tick;
        branch_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (bus.rd_req !== 1'b0 || stall !== 1'b0 || is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL miss_flush_idle%0d: rd_req=%b stall=%b valid=%b want 0/0/0", i, bus.rd_req, stall, is_valid_out); end
            tick;
        end
        $display("[TB] flush in MISS pc=%h", pc);
    endtask

    task automatic test_reset_mid_refill;
        pc = 32'h1C00_4000; inst_en = 1'b1;
        tick;
        tick;
        bus.rd_rdy = 1'b1;
        tick;
        bus.rd_rdy = 1'b0;
        bus.ret_valid = 1'b1; bus.ret_data = 32'hE0; bus.ret_last = 1'b0;
        tick;
        bus.ret_data = 32'hE1; rst = 1'b1;
        tick;
        #1;
        tests_run++; if (stall !== 1'b0 || is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stall_valid: %b/%b want 0/0", stall, is_valid_out); end
        tests_run++; if (bus.rd_req !== 1'b0 || bus.rd_addr !== 32'h0) begin tests_failed++; $display("FAIL rstmid_rd: req=%b addr=%h want 0/0", bus.rd_req, bus.rd_addr); end
        tests_run++; if (inst !== 32'h0 || pc_out !== 32'h0) begin tests_failed++; $display("FAIL rstmid_inst_pc: %h/%h want 0/0", inst, pc_out); end
        rst = 1'b0; inst_en = 1'b0;
        bus.ret_data = 32'hE2;
        tick;
        bus.ret_data = 32'hE3; bus.ret_last = 1'b1;
        #1;
        tests_run++; if (stall !== 1'b0 || bus.rd_req !== 1'b0) begin tests_failed++; $display("FAIL stray_beats: stall=%b rd_req=%b want 0/0", stall, bus.rd_req); end
        tick;
        bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
        pc = 32'h1C00_2018; inst_en = 1'b1;
        tick;
        #1;
        tests_run++; if (stall !== 1'b1 || is_valid_out !== 1'b0) begin tests_failed++; $display("FAIL line_lost_after_rst: stall=%b valid=%b want 1/0", stall, is_valid_out); end
        $display("[TB] reset mid-refill, refetch pc=%h stall=%b", pc, stall);
        inst_en = 1'b0; branch_flush = 1'b1;
        tick;
        branch_flush = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b1; pc = '0; inst_en = 1'b0; branch_flush = 1'b0;
        bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = '0;
        test_reset();
        test_cold_miss_sequential();
        test_conflict();
        test_flush_on_hit();
        test_flush_in_refill();
        test_flush_in_miss();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
